// File: rtl/button_pkg.sv
// Shared definitions for the board push-button front end: FSM state
// encoding and the raw-pin polarity helper.
package button_pkg;

  // Debounce FSM states; the encoding is shared so that other board-input
  // blocks and checkers agree on it.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } db_state_e;

  // Map a synchronized pin level onto an active-high "button pressed" level.
  function automatic logic normalise_level(input logic raw_level, input logic active_low);
    return raw_level ^ active_low;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous board input. The reset value
// is configurable so that each input can park at its own inactive level.
module sync_2ff #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Two back-to-back flops give the first stage a full cycle to settle.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= RESET_VALUE;
      sync_r <= RESET_VALUE;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/button_debounce.sv
// Push-button debouncer: synchronizes the raw pin, qualifies press and
// release against a stable-level window and reports a long press once per
// press. All outputs come straight from flops.
module button_debounce
  import button_pkg::*;
#(
  parameter int CLOCK_FREQUENCY   = 27000000,
  parameter int DEBOUNCE_CYCLES   = 270000,
  parameter int LONG_PRESS_CYCLES = 27000000,
  parameter int BUTTON_ACTIVE_LOW = 0
) (
  input  logic system_clk,
  input  logic system_rst,
  input  logic button_in,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press_pulse
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_ZERO   = DB_W'(0);
  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);

  localparam logic ACTIVE_LOW = (BUTTON_ACTIVE_LOW != 0);

  logic              sync_q_s;
  logic              level_s;
  db_state_e         state_r;
  logic [DB_W-1:0]   db_cnt_r;
  logic [HOLD_W-1:0] hold_cnt_r;
  logic              pressed_r;
  logic              press_pulse_r;
  logic              release_pulse_r;
  logic              long_press_pulse_r;

  // The synchronizer resets to the released pin level so reset never looks
  // like a press.
  sync_2ff #(
    .RESET_VALUE (ACTIVE_LOW)
  ) u_sync (
    .clk (system_clk),
    .rst (system_rst),
    .d   (button_in),
    .q   (sync_q_s)
  );

  assign level_s = normalise_level(sync_q_s, ACTIVE_LOW);

  // Debounce FSM with its counters and registered level/pulse outputs.
  always_ff @(posedge system_clk) begin
    if (system_rst) begin
      state_r            <= IDLE;
      db_cnt_r           <= DB_ZERO;
      hold_cnt_r         <= HOLD_ZERO;
      pressed_r          <= 1'b0;
      press_pulse_r      <= 1'b0;
      release_pulse_r    <= 1'b0;
      long_press_pulse_r <= 1'b0;
    end else begin
      press_pulse_r      <= 1'b0;
      release_pulse_r    <= 1'b0;
      long_press_pulse_r <= 1'b0;

      case (state_r)
        IDLE: begin
          if (level_s) begin
            state_r  <= PRESS_DB;
            db_cnt_r <= DB_ZERO;
          end
        end
        PRESS_DB: begin
          if (!level_s) begin
            // Glitch: drop back without telling anyone.
            state_r <= IDLE;
          end else if (db_cnt_r == DB_LAST) begin
            state_r       <= HELD;
            press_pulse_r <= 1'b1;
            pressed_r     <= 1'b1;
            hold_cnt_r    <= HOLD_ZERO;
          end else begin
            db_cnt_r <= db_cnt_r + DB_ONE;
          end
        end
        HELD: begin
          if (!level_s) begin
            state_r  <= REL_DB;
            db_cnt_r <= DB_ZERO;
          end
        end
        REL_DB: begin
          if (level_s) begin
            // Bounce while held: resume without re-arming the hold timer.
            state_r <= HELD;
          end else if (db_cnt_r == DB_LAST) begin
            state_r         <= IDLE;
            release_pulse_r <= 1'b1;
            pressed_r       <= 1'b0;
          end else begin
            db_cnt_r <= db_cnt_r + DB_ONE;
          end
        end
        default: begin
          state_r   <= IDLE;
          db_cnt_r  <= DB_ZERO;
          pressed_r <= 1'b0;
        end
      endcase

      // The hold timer runs for the whole press, including release
      // qualification, and saturates so the long-press pulse fires once.
      if ((state_r == HELD) || (state_r == REL_DB)) begin
        if (hold_cnt_r != HOLD_MAX) begin
          hold_cnt_r <= hold_cnt_r + HOLD_ONE;
        end
        if (hold_cnt_r == HOLD_LAST) begin
          long_press_pulse_r <= 1'b1;
        end
      end
    end
  end

  assign pressed          = pressed_r;
  assign press_pulse      = press_pulse_r;
  assign release_pulse    = release_pulse_r;
  assign long_press_pulse = long_press_pulse_r;

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20).
// Two instances run side by side: active-high pin and active-low pin driven
// with the inverted level; both must match one reference model built from
// run lengths of the delayed button level.
module tb_button_debounce;

  localparam int DB = 4;
  localparam int LP = 20;

  logic system_clk = 1'b0;
  logic system_rst;
  logic button_hi;
  logic button_lo;

  logic hi_pressed, hi_press_pulse, hi_release_pulse, hi_long_pulse;
  logic lo_pressed, lo_press_pulse, lo_release_pulse, lo_long_pulse;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state.
  logic m_d0, m_d1;
  logic m_pressed, m_pp, m_rp, m_lp;
  int   m_ones, m_zeros, m_since;

  button_debounce #(
    .CLOCK_FREQUENCY   (27000000),
    .DEBOUNCE_CYCLES   (DB),
    .LONG_PRESS_CYCLES (LP),
    .BUTTON_ACTIVE_LOW (0)
  ) dut_hi (
    .system_clk       (system_clk),
    .system_rst       (system_rst),
    .button_in        (button_hi),
    .pressed          (hi_pressed),
    .press_pulse      (hi_press_pulse),
    .release_pulse    (hi_release_pulse),
    .long_press_pulse (hi_long_pulse)
  );

  button_debounce #(
    .CLOCK_FREQUENCY   (27000000),
    .DEBOUNCE_CYCLES   (DB),
    .LONG_PRESS_CYCLES (LP),
    .BUTTON_ACTIVE_LOW (1)
  ) dut_lo (
    .system_clk       (system_clk),
    .system_rst       (system_rst),
    .button_in        (button_lo),
    .pressed          (lo_pressed),
    .press_pulse      (lo_press_pulse),
    .release_pulse    (lo_release_pulse),
    .long_press_pulse (lo_long_pulse)
  );

  always #5 system_clk = ~system_clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock edge of the reference: the FSM sees the level from two edges
  // back; a press is qualified after DB+1 consecutive high samples while
  // released, a release after DB+1 consecutive low samples while pressed,
  // and the long press fires LP edges after the press edge.
  task automatic model_edge(input logic rst, input logic lvl);
    logic s;
    if (rst) begin
      m_d0 = 1'b0; m_d1 = 1'b0;
      m_pressed = 1'b0; m_pp = 1'b0; m_rp = 1'b0; m_lp = 1'b0;
      m_ones = 0; m_zeros = 0; m_since = 0;
    end else begin
      s = m_d1;
      m_d1 = m_d0;
      m_d0 = lvl;
      m_pp = 1'b0; m_rp = 1'b0; m_lp = 1'b0;
      if (s) begin
        m_ones++;
        m_zeros = 0;
      end else begin
        m_zeros++;
        m_ones = 0;
      end
      if (m_pressed && (m_since < LP)) begin
        m_since++;
        if (m_since == LP) m_lp = 1'b1;
      end
      if (!m_pressed && (m_ones == DB + 1)) begin
        m_pp = 1'b1;
        m_pressed = 1'b1;
        m_since = 0;
      end else if (m_pressed && (m_zeros == DB + 1)) begin
        m_rp = 1'b1;
        m_pressed = 1'b0;
      end
    end
  endtask

  // Hold the inputs for n cycles, stepping the model and checking both
  // instances half a cycle after every rising edge.
  task automatic apply(input logic rst, input logic lvl, input int n);
    for (int i = 0; i < n; i++) begin
      system_rst = rst;
      button_hi  = lvl;
      button_lo  = ~lvl;
      @(posedge system_clk);
      model_edge(rst, lvl);
      @(negedge system_clk);
      chk("hi_pressed",  hi_pressed,       m_pressed);
      chk("hi_press",    hi_press_pulse,   m_pp);
      chk("hi_release",  hi_release_pulse, m_rp);
      chk("hi_long",     hi_long_pulse,    m_lp);
      chk("lo_pressed",  lo_pressed,       m_pressed);
      chk("lo_press",    lo_press_pulse,   m_pp);
      chk("lo_release",  lo_release_pulse, m_rp);
      chk("lo_long",     lo_long_pulse,    m_lp);
    end
  endtask

  initial begin
    int lvl;
    int len;
    system_rst = 1'b1;
    button_hi  = 1'b0;
    button_lo  = 1'b1;
    @(negedge system_clk);

    // Reset state.
    apply(1'b1, 1'b0, 3);
    // Clean press held 15 cycles, then released.
    apply(1'b0, 1'b0, 6);
    apply(1'b0, 1'b1, 15);
    apply(1'b0, 1'b0, 15);
    // Short glitches: 3 cycles and 1 cycle high.
    apply(1'b0, 1'b1, 3);
    apply(1'b0, 1'b0, 10);
    apply(1'b0, 1'b1, 1);
    apply(1'b0, 1'b0, 8);
    // Long hold: long press exactly once.
    apply(1'b0, 1'b1, 40);
    apply(1'b0, 1'b0, 12);
    // Two-cycle low bounce while held.
    apply(1'b0, 1'b1, 15);
    apply(1'b0, 1'b0, 2);
    apply(1'b0, 1'b1, 10);
    apply(1'b0, 1'b0, 12);
    // Bounce of exactly DB low samples is still rejected.
    apply(1'b0, 1'b1, 12);
    apply(1'b0, 1'b0, DB);
    apply(1'b0, 1'b1, 8);
    apply(1'b0, 1'b0, 12);
    // Reset for one cycle during HELD with the button still down.
    apply(1'b0, 1'b1, 12);
    apply(1'b1, 1'b1, 1);
    apply(1'b0, 1'b1, 15);
    apply(1'b0, 1'b0, 12);
    // Release while the hold timer is near the long-press point.
    apply(1'b0, 1'b1, 24);
    apply(1'b0, 1'b0, 10);

    // Randomized runs of levels with occasional resets.
    for (int k = 0; k < 60; k++) begin
      lvl = $urandom_range(0, 1);
      if ($urandom_range(0, 4) == 0) len = $urandom_range(20, 32);
      else len = $urandom_range(1, 9);
      if ($urandom_range(0, 14) == 0) apply(1'b1, lvl[0], 1);
      apply(1'b0, lvl[0], len);
    end
    apply(1'b0, 1'b0, 12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 SHALL have parameter CLOCK_FREQUENCY, default 27000000, the system clock frequency in Hz (informational only).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 270000 (10 ms): the stable-level qualification length; legal range >= 1.
REQ-003 SHALL have parameter LONG_PRESS_CYCLES, default 27000000 (1 s): the hold time to long press; must be > DEBOUNCE_CYCLES.
REQ-004 SHALL have parameter BUTTON_ACTIVE_LOW, default 0; when 1, the raw input is inverted before the FSM.
REQ-005 SHALL have ports:
- system_clk  input  1  system clock; one clock; reset is synchronous and active-high
- system_rst  input  1  synchronous active-high reset
- button_in  input  1  raw asynchronous button pin
- pressed  output  1  debounced level, 1 = pressed
- press_pulse  output  1  one-cycle pulse on a qualified press
- release_pulse  output  1  one-cycle pulse on a qualified release
- long_press_pulse  output  1  one-cycle pulse, at most once per press

Function
REQ-006 SHALL pass button_in through a 2-flop synchronizer, then normalise it to active-high level s.
REQ-007 SHALL implement the FSM states IDLE, PRESS_DB, HELD and REL_DB, together with a debounce counter db_cnt and a hold counter hold_cnt.
REQ-008 IDLE: s=1 -> PRESS_DB, db_cnt=0; otherwise remain.
REQ-009 PRESS_DB: s=0 -> IDLE, no pulse (glitch rejected); s=1 and db_cnt==DEBOUNCE_CYCLES-1 -> HELD, press_pulse=1, pressed=1, hold_cnt=0; else db_cnt+1.
REQ-010 HELD: s=0 -> REL_DB, db_cnt=0; hold_cnt increments, saturating at LONG_PRESS_CYCLES; long_press_pulse=1 in the single cycle hold_cnt reaches LONG_PRESS_CYCLES-1.
REQ-011 REL_DB: s=1 -> HELD, hold_cnt preserved, no pulse; s=0 and db_cnt==DEBOUNCE_CYCLES-1 -> IDLE, release_pulse=1, pressed=0; else db_cnt+1; hold_cnt keeps counting and may fire long_press_pulse.
REQ-012 Latency: if button_in is stably asserted from clock edge N, press_pulse SHALL be high in the cycle following edge N+2+DEBOUNCE_CYCLES; release latency is symmetric.
REQ-013 All outputs SHALL be registered; the pulses are exactly one cycle wide, and press_pulse and release_pulse are never high together.
REQ-014 pressed SHALL remain 1 throughout REL_DB and remain 0 throughout PRESS_DB.
REQ-015 Counter widths SHALL be $clog2(param+1); counters never wrap.

Reset
REQ-016 With system_rst high at an edge: state=IDLE, db_cnt=hold_cnt=0, synchronizer flops at the inactive level, and all outputs 0 from the next cycle.
REQ-017 Reset mid-press SHALL NOT emit release_pulse; if the button is still held after reset, a full new press qualification SHALL follow (REQ-012 timing from the reset release edge).

Structure
REQ-018 The FSM state encoding (2-bit enum IDLE/PRESS_DB/HELD/REL_DB) SHALL live in the shared package button_pkg.
REQ-019 The synchronizer SHALL be the sub-module sync_2ff (1 bit, configurable reset value), reusable for the other board inputs.

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20)
REQ-020 Clean press from edge 10, held 15 cycles, then released -> press_pulse after edge 16, pressed=1, release_pulse 6 edges after release, no long_press_pulse.
REQ-021 3-cycle glitch high -> no pulses, pressed stays 0, FSM back to IDLE.
REQ-022 Hold 40 cycles -> long_press_pulse exactly once, 20 cycles after press_pulse.
REQ-023 2-cycle low bounce while held -> no release_pulse, no second press_pulse, pressed stays 1.
REQ-024 Reset for 1 cycle during HELD with the button still high -> outputs 0, no release_pulse, then press_pulse 6 edges after reset deasserts.
REQ-025 BUTTON_ACTIVE_LOW=1, button_in driven 0 -> same responses as REQ-020.
